// File: rtl/sum_accum_32bit_pkg.sv
// Shared constants for the burst accumulator: state encoding and datapath width.
package sum_accum_32bit_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sum_accum_32bit_rca.sv
// 32-bit ripple-carry adder without carry-in; one full-adder cell per bit.
import sum_accum_32bit_pkg::*;

module rca_32bit (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] Sout,
  output logic              Cout
);

  logic [DATA_W:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < DATA_W; i++) begin : g_fa
    assign Sout[i]  = A[i] ^ B[i] ^ c[i];
    assign c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Cout = c[DATA_W];

endmodule

// File: rtl/sum_accum_32bit.sv
// Burst accumulator: sums len words through rca_32bit and hands back the total
// with a sticky unsigned-overflow flag over a valid/ready result handshake.
//
// state | meaning
// IDLE  | waiting for start; result of last burst still on Sum/Carry
// ACCUM | accepting words, one per handshake, until remaining reaches zero
// DONE  | result valid, held until out_ready
import sum_accum_32bit_pkg::*;

module sum_accum_32bit #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COUNT_W-1:0] len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  Sum,
  output logic               Carry,
  output logic               busy
);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   acc_q;
  logic                carry_q;
  logic [COUNT_W-1:0]  rem_q;
  logic [DATA_W-1:0]   sout;
  logic                cout;
  logic                accept;

  rca_32bit u_rca (
    .A    (acc_q),
    .B    (in_data),
    .Sout (sout),
    .Cout (cout)
  );

  assign accept = (state_q == ACCUM) && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len == '0) ? DONE : ACCUM;
      ACCUM:   if (in_valid && rem_q == COUNT_W'(1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sum/Carry are only cleared by a new start so the last result survives IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
      rem_q   <= '0;
    end else if (state_q == IDLE && start) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
      rem_q   <= len;
    end else if (accept) begin
      acc_q   <= sout;
      carry_q <= carry_q | cout;
      rem_q   <= rem_q - COUNT_W'(1);
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign Sum       = acc_q;
  assign Carry     = carry_q;

endmodule

// File: tb/tb_sum_accum_32bit.sv
// Randomized self-checking bench for sum_accum_32bit against a wide-integer
// model of the burst total.
module tb_sum_accum_32bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] Sum;
  logic        Carry;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wq[$];
  bit          vq[$];

  sum_accum_32bit #(.COUNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Carry     (Carry),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives one burst at negedges; the model is the true (unbounded) total.
  task automatic run_burst(input int L, input int rmode, input int hold, input bit mid_start);
    logic [63:0] total;
    logic [31:0] d;
    bit          v;
    int          acc_n;
    int          budget;
    total  = '0;
    acc_n  = 0;
    budget = 0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    start = 1'b1;
    len   = L[7:0];
    @(negedge clk);
    start = 1'b0;
    while (acc_n < L && budget < 1000) begin
      chk("in_ready", in_ready, 1);
      chk("out_valid_accum", out_valid, 0);
      chk("sum_partial", Sum, total[31:0]);
      chk("carry_partial", Carry, total[63:32] != 0);
      if (vq.size() != 0) v = vq.pop_front();
      else if (rmode == 0) v = 1'b1;
      else v = ($urandom_range(0, 2) != 0);
      if (wq.size() != 0) d = wq.pop_front();
      else if ($urandom_range(0, 3) == 0) d = $urandom_range(0, 255);
      else d = $urandom;
      in_valid = v;
      in_data  = d;
      if (mid_start && budget == 1) begin
        start = 1'b1;
        len   = 8'(L + 3);
      end else begin
        start = 1'b0;
      end
      if (v) begin
        total = total + {32'd0, d};
        acc_n++;
      end
      @(negedge clk);
      budget++;
    end
    start = 1'b0;
    chk("accum_count", acc_n, L);
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    for (int i = 0; i <= hold; i++) begin
      chk("out_valid", out_valid, 1);
      chk("in_ready_done", in_ready, 0);
      chk("sum_final", Sum, total[31:0]);
      chk("carry_final", Carry, total[63:32] != 0);
      if (i == hold) out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("idle_after", busy, 0);
    chk("out_valid_idle", out_valid, 0);
    chk("sum_kept", Sum, total[31:0]);
    chk("carry_kept", Carry, total[63:32] != 0);
  endtask

  initial begin
    #2;
    chk("rst_sum", Sum, 0);
    chk("rst_carry", Carry, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    wq = '{32'd1, 32'd2, 32'd3};
    run_burst(3, 0, 0, 1'b0);

    wq = '{32'hFFFF_FFFF, 32'h0000_0002};
    run_burst(2, 0, 0, 1'b0);

    wq = '{32'd10, 32'd20, 32'd30, 32'd40};
    vq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    run_burst(4, 0, 2, 1'b0);
    vq.delete();

    run_burst(0, 0, 5, 1'b0);

    run_burst(5, 1, 1, 1'b1);

    // Reset mid-burst after 2 of 4 words.
    @(negedge clk);
    start = 1'b1;
    len   = 8'd4;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h8000_0000;
    @(negedge clk);
    in_data = 32'h9000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_sum", Sum, 64'h0000_0000_1000_0000);
    chk("pre_rst_carry", Carry, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", Sum, 0);
    chk("mid_rst_carry", Carry, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 25; k++)
      run_burst($urandom_range(1, 12), 1, $urandom_range(0, 3), ($urandom_range(0, 3) == 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
